// File: rtl/ni_inject_fifo.sv
// Network-interface injection FIFO: absorbs a non-stallable flit stream from the
// dataout buffer and presents it first-word-fall-through to the router with a
// valid/ready handshake. Keeps saturating drop/sent/source-error statistics.
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module ni_inject_fifo #(
    parameter int unsigned DW      = 20,
    parameter int unsigned DEPTH   = 8,
    parameter logic [3:0]  NODE_ID = 4'd0,
    parameter int unsigned CW      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DW-1:0]            in_data,
    input  logic                     in_valid,
    output logic [DW-1:0]            flit_out,
    output logic                     flit_valid,
    input  logic                     flit_ready,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CW-1:0]            drop_cnt,
    output logic [CW-1:0]            sent_cnt,
    output logic [CW-1:0]            src_err_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] sent_q, sent_d;
    logic [CW-1:0] err_q, err_d;

    logic push, pop, src_mismatch;

    // Handshake decode; a pop frees a slot in the same cycle so a full FIFO can still accept.
    always_comb begin
        empty        = (level_q == '0);
        full         = (level_q == FULL_LEVEL);
        flit_valid   = !empty;
        pop          = flit_valid & flit_ready;
        push         = in_valid & (!full | pop);
        src_mismatch = (in_data[15:12] != NODE_ID);
    end

    // Head-of-queue output; forced to zero when empty so reset shows a clean bus.
    always_comb begin
        flit_out = empty ? '0 : mem[rd_ptr_q];
    end

    // Next-state for pointers and occupancy.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + (AW + 1)'(1);
            2'b01:   level_d = level_q - (AW + 1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Next-state for the saturating statistics counters.
    always_comb begin
        drop_d = drop_q;
        sent_d = sent_q;
        err_d  = err_q;
        if (in_valid && !push && drop_q != CNT_MAX) drop_d = drop_q + CW'(1);
        if (pop && sent_q != CNT_MAX)               sent_d = sent_q + CW'(1);
        if (push && src_mismatch && err_q != CNT_MAX) err_d = err_q + CW'(1);
    end

    // Control and statistics state; reset discards any stored flits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= '0;
            sent_q   <= '0;
            err_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            drop_q   <= drop_d;
            sent_q   <= sent_d;
            err_q    <= err_d;
        end
    end

    // Flit storage; contents are don't-care after reset so no reset is applied.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= in_data;
    end

    assign level       = level_q;
    assign drop_cnt    = drop_q;
    assign sent_cnt    = sent_q;
    assign src_err_cnt = err_q;

endmodule
